pc_fetch_sequencer: RTL and testbench

- Fetch/flow controller that owns the program counter and sequences instruction fetch from instruction memory.
- Per instruction: issues a fetch request at the PC, waits for the memory acknowledge, presents the instruction to the decoder, then applies the decoder's flow op (sequential / jump / call / return).
- Holds a small return-address stack for call/return.
- Sits between the instruction memory and the decode stage.

---
 rtl/pc_fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner: fetches from instruction memory, hands the word to decode,
// then applies the decoder's flow op (SEQ/JMP/CALL/RET) using a small return stack.
module pc_fetch_sequencer #(
  parameter int          AW          = 4,
  parameter int          DW          = 8,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0,
  localparam int         IW          = $clog2(STACK_DEPTH),
  localparam int         SPW         = IW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           halt_req,
  output logic           imem_req,
  output logic [AW-1:0]  imem_addr,
  input  logic           imem_ack,
  input  logic [DW-1:0]  imem_rdata,
  output logic [DW-1:0]  instr,
  output logic           instr_valid,
  input  logic           op_valid,
  input  logic [1:0]     op_code,
  input  logic [AW-1:0]  op_target,
  output logic [AW-1:0]  pc,
  output logic [SPW-1:0] sp,
  output logic           halted,
  output logic           stk_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  state_t         state, state_nxt;
  logic [AW-1:0]  pc_nxt;
  logic [SPW-1:0] sp_nxt;
  logic           push, load_instr, err_set, err_clr, op_ok;
  logic [AW-1:0]  pc_inc;
  logic [IW-1:0]  top_idx;
  logic [SPW-1:0] sp_dec;
  logic [AW-1:0]  stack [STACK_DEPTH];

  assign pc_inc  = pc + AW'(1);
  assign sp_dec  = sp - SPW'(1);
  assign top_idx = sp_dec[IW-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    sp_nxt     = sp;
    push       = 1'b0;
    load_instr = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    op_ok      = 1'b1;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          load_instr = 1'b1;
          state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_valid) begin
          case (op_code)
            OP_SEQ: pc_nxt = pc_inc;
            OP_JMP: pc_nxt = op_target;
            OP_CALL: begin
              if (sp < SPW'(STACK_DEPTH)) begin
                push   = 1'b1;
                sp_nxt = sp + SPW'(1);
                pc_nxt = op_target;
              end else begin
                op_ok = 1'b0;
              end
            end
            OP_RET: begin
              if (sp != '0) begin
                pc_nxt = stack[top_idx];
                sp_nxt = sp_dec;
              end else begin
                op_ok = 1'b0;
              end
            end
            default: pc_nxt = pc;
          endcase
          // A stack fault leaves pc/sp untouched and parks the sequencer.
          if (op_ok) begin
            state_nxt = halt_req ? S_HALTED : S_FETCH;
          end else begin
            err_set   = 1'b1;
            state_nxt = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        if (start) begin
          state_nxt = S_FETCH;
          err_clr   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= AW'(RESET_ADDR);
      sp      <= '0;
      instr   <= '0;
      stk_err <= 1'b0;
    end else begin
      pc <= pc_nxt;
      sp <= sp_nxt;
      if (load_instr) instr <= imem_rdata;
      if (err_set)      stk_err <= 1'b1;
      else if (err_clr) stk_err <= 1'b0;
    end
  end

  // Stack contents need no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push) stack[sp[IW-1:0]] <= pc_inc;
  end

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_EXEC);
  assign halted      = (state == S_HALTED);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed + randomized bench for pc_fetch_sequencer, checked every cycle against a
// mode/queue-level reference model.
module tb_pc_fetch_sequencer;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PCMOD = 1 << AW;

  localparam int M_IDLE   = 0;
  localparam int M_FETCH  = 1;
  localparam int M_EXEC   = 2;
  localparam int M_HALTED = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, halt_req, imem_ack, op_valid;
  logic [1:0]    op_code;
  logic [AW-1:0] op_target;
  logic [DW-1:0] imem_rdata;
  logic          imem_req, instr_valid, halted, stk_err;
  logic [AW-1:0] imem_addr, pc;
  logic [DW-1:0] instr;
  logic [2:0]    sp;

  int errors = 0;
  int checks = 0;

  int m_mode  = M_IDLE;
  int m_pc    = 0;
  int m_instr = 0;
  int m_err   = 0;
  int m_stack[$];

  pc_fetch_sequencer #(.AW(AW), .DW(DW), .STACK_DEPTH(DEPTH), .RESET_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .op_valid(op_valid), .op_code(op_code), .op_target(op_target),
    .pc(pc), .sp(sp), .halted(halted), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit s, h, a, ov, r, input int c, t, d);
    bit ok;
    if (r) begin
      m_mode = M_IDLE; m_pc = 0; m_instr = 0; m_err = 0; m_stack.delete();
      return;
    end
    case (m_mode)
      M_IDLE:  if (s) m_mode = M_FETCH;
      M_FETCH: if (a) begin m_instr = d; m_mode = M_EXEC; end
      M_EXEC: if (ov) begin
        ok = 1;
        case (c)
          0: m_pc = (m_pc + 1) % PCMOD;
          1: m_pc = t;
          2: if (m_stack.size() < DEPTH) begin
               m_stack.push_back((m_pc + 1) % PCMOD);
               m_pc = t;
             end else ok = 0;
          default: if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                   else ok = 0;
        endcase
        if (!ok) begin m_err = 1; m_mode = M_HALTED; end
        else m_mode = h ? M_HALTED : M_FETCH;
      end
      default: if (s) begin m_mode = M_FETCH; m_err = 0; end
    endcase
  endtask

  // One clock: drive on the falling edge, check outputs, advance the model, wait for the rise.
  task automatic step(input bit s, h, a, ov, r, input logic [1:0] c, input logic [AW-1:0] t);
    logic [DW-1:0] d;
    @(negedge clk);
    d = DW'($urandom);
    start = s; halt_req = h; imem_ack = a; imem_rdata = d;
    op_valid = ov; op_code = c; op_target = t; rst = r;
    #1;
    chk("imem_req",    imem_req,    m_mode == M_FETCH);
    chk("imem_addr",   imem_addr,   m_pc);
    chk("pc",          pc,          m_pc);
    chk("instr",       instr,       m_instr);
    chk("instr_valid", instr_valid, m_mode == M_EXEC);
    chk("halted",      halted,      m_mode == M_HALTED);
    chk("sp",          sp,          m_stack.size());
    chk("stk_err",     stk_err,     m_err);
    model_update(s, h, a, ov, r, int'(c), int'(t), int'(d));
    @(posedge clk);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 2'd0, '0);
  endtask

  task automatic do_instr(input logic [1:0] c, input logic [AW-1:0] t, input bit h, input int dly);
    for (int i = 0; i < dly; i++) idle_step();
    step(0, 0, 1, 0, 0, 2'd0, '0);
    step(0, h, 0, 1, 0, c, t);
  endtask

  initial begin
    rst = 1'b1; start = 0; halt_req = 0; imem_ack = 0; imem_rdata = '0;
    op_valid = 0; op_code = 2'd0; op_target = '0;
    @(posedge clk);
    step(0, 0, 0, 0, 1, 2'd0, '0);

    // Sequential run with immediate acks: addresses 0..15 then wrap to 0.
    step(1, 0, 0, 0, 0, 2'd0, '0);
    for (int i = 0; i < 17; i++) do_instr(2'd0, '0, 0, 0);
    #2 chk("pc_after_wrap", pc, 1);

    // Slow memory at pc=5.
    do_instr(2'd1, 4'h5, 0, 0);
    do_instr(2'd0, '0, 0, 3);
    #2 chk("pc_after_slow", pc, 6);

    // JMP/CALL/SEQ/RET.
    do_instr(2'd1, 4'h3, 0, 0);
    do_instr(2'd1, 4'hA, 0, 0);
    do_instr(2'd2, 4'h2, 0, 0);
    #2 chk("sp_after_call", sp, 1);
    do_instr(2'd0, '0, 0, 0);
    do_instr(2'd3, '0, 0, 0);
    #2 chk("pc_after_ret", pc, 4'hB);
    chk("sp_after_ret", sp, 0);

    // Overflow on the fifth nested CALL.
    for (int i = 0; i < 5; i++) do_instr(2'd2, 4'h1, 0, 0);
    #2 chk("ovf_halted", halted, 1);
    chk("ovf_err", stk_err, 1);
    chk("ovf_sp", sp, 4);
    chk("ovf_pc", pc, 1);
    idle_step();
    step(1, 0, 0, 0, 0, 2'd0, '0);
    #2 chk("ovf_resume_err", stk_err, 0);
    chk("ovf_resume_addr", imem_addr, 1);

    // Drain the stack, then underflow.
    for (int i = 0; i < 5; i++) do_instr(2'd3, '0, 0, 0);
    #2 chk("udf_err", stk_err, 1);
    chk("udf_halted", halted, 1);
    chk("udf_pc", pc, 4'hC);
    step(1, 0, 0, 0, 0, 2'd0, '0);

    // halt_req alongside JMP 7.
    do_instr(2'd1, 4'h7, 1, 0);
    #2 chk("halt_pc", pc, 7);
    chk("halt_state", halted, 1);
    for (int i = 0; i < 3; i++) idle_step();
    step(1, 0, 0, 0, 0, 2'd0, '0);
    #2 chk("halt_resume_addr", imem_addr, 7);
    chk("halt_resume_req", imem_req, 1);

    // Reset mid-fetch, late ack ignored, then reset mid-exec.
    step(0, 0, 0, 0, 1, 2'd0, '0);
    step(0, 0, 1, 0, 0, 2'd0, '0);
    #2 chk("late_ack_req", imem_req, 0);
    chk("late_ack_instr", instr, 0);
    chk("rst_pc", pc, 0);
    step(1, 0, 0, 0, 0, 2'd0, '0);
    do_instr(2'd2, 4'h9, 0, 0);
    step(0, 0, 1, 0, 0, 2'd0, '0);
    step(0, 0, 0, 1, 1, 2'd1, 4'h4);
    #2 chk("rst_exec_valid", instr_valid, 0);
    chk("rst_exec_sp", sp, 0);
    chk("rst_exec_pc", pc, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) == 0, 2'($urandom), AW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
